connect4_move_sequencer: RTL
============================

Name: connect4_move_sequencer

Overview:
- Sequences one player move through the board datapath: accepts a column choice, computes the landing row from per-column fill counters, issues the board write, then runs a start/done handshake with the external win checker.
- Produces the game-status code and the turn bit that drive the game FSM's `in_game_status` and `player_turn` inputs.
- Sits between the input/debounce logic and the board RAM, win checker and game FSM.

Parameters:
- ROWS, 6, board rows; row 0 is the bottom row.
- COLS, 7, board columns.
- TIMEOUT_CYCLES, 50_000_000, idle cycles before a forfeit-pass (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fsm_state  in  2  game FSM current_state: 00 init, 01 P1 turn, 10 P2 turn, 11 end
- move_valid  in  1  column request valid
- move_col  in  3  requested column, 0..COLS-1
- move_ready  out  1  sequencer can accept a move this cycle
- move_reject  out  1  one-cycle pulse: request was for a full or out-of-range column
- wr_en  out  1  one-cycle board write strobe
- wr_row  out  3  board write row
- wr_col  out  3  board write column
- wr_player  out  1  piece owner: 0 = P1, 1 = P2
- chk_start  out  1  one-cycle win-check launch
- chk_row  out  3  last-placed row; held stable from chk_start until chk_done
- chk_col  out  3  last-placed column; held stable from chk_start until chk_done
- chk_done  in  1  win checker finished (single-cycle pulse)
- chk_win  in  1  qualified by chk_done: the last move made four in a row
- game_status  out  2  00 next turn, 01 P1 win, 10 P2 win, 11 tie
- player_turn  out  1  0 = P1 to move, 1 = P2 to move

Behaviour:
- Reset values (reset is synchronous, active-high): state IDLE; all height counters 0; move counter 0; player_turn 0; game_status 00; all strobes 0; wr_* and chk_* outputs 0.
- Reset asserted in any state, including mid-check, aborts the move. chk_done arriving after reset is ignored.
- States: IDLE, WAIT_MOVE, WRITE, CHECK, REPORT, DONE.
- IDLE → WAIT_MOVE when fsm_state is 01 or 10.
- WAIT_MOVE:
  - move_ready = 1 only in WAIT_MOVE, and only while fsm_state equals 01 (when player_turn=0) or 10 (when player_turn=1).
  - A handshake occurs on move_valid & move_ready.
  - If move_col >= COLS or height[move_col] == ROWS: move_reject = 1 in the next cycle; state stays WAIT_MOVE; no counter changes.
  - Otherwise: latch col and row = height[col]; go to WRITE.
- WRITE (exactly 1 cycle):
  - wr_en = 1, with wr_row/wr_col = latched row/col and wr_player = player_turn.
  - height[col] += 1; move counter += 1 (7-bit, saturates at ROWS*COLS).
  - Next state CHECK, with chk_start = 1 on the first CHECK cycle only.
- CHECK: wait indefinitely for chk_done. move_valid is ignored (move_ready = 0). chk_done in any other state is ignored.
- REPORT (1 cycle, decision taken on the chk_done capture), in priority order:
  - chk_win = 1 → game_status = 01 if player_turn = 0, else 10; go to DONE.
  - Else move counter == ROWS*COLS → game_status = 11; go to DONE.
  - Else game_status = 00; toggle player_turn; go to WAIT_MOVE.
- DONE: game_status and player_turn held; no writes or checks issued; leave only on reset.
- Latency: move accept → wr_en is 1 cycle; wr_en → chk_start is 1 cycle; chk_done → player_turn toggle is 2 cycles.
- game_status stays 00 outside REPORT/DONE.
- A win on the 42nd move reports the win, not a tie.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- Defined:
  - A 26-bit idle counter runs in WAIT_MOVE and clears on every handshake (accepted or rejected).
  - When it reaches TIMEOUT_CYCLES-1 with no handshake: player_turn toggles, game_status = 00 for 1 cycle, no board write, counter clears.
- Undefined: no counter; WAIT_MOVE waits indefinitely.

Test Plan:
1. Reset, fsm_state=01, move_col=3 valid → wr_en one cycle later with wr_row=0, wr_col=3, wr_player=0. Next cycle chk_start=1. chk_done=1, chk_win=0 → 2 cycles later game_status=00 and player_turn=1.
2. Six accepted moves to column 2 (alternating players, checker answers no-win) → rows 0..5 written. Seventh request to column 2 → move_reject pulse, no wr_en, player_turn unchanged.
3. move_col=7 → move_reject=1, state remains WAIT_MOVE. move_col=7 with fsm_state=00 → move_ready=0, no reject.
4. P2 move, checker returns chk_win=1 → game_status=10 held in DONE. Further move_valid gives no wr_en and no chk_start.
5. Fill all 42 cells with no win → after the 42nd REPORT, game_status=11. Repeat with chk_win=1 on the 42nd move → game_status=01 or 10, not 11.
6. Assert reset while in CHECK, then pulse chk_done → all outputs at reset values, heights 0, next move writes row 0. With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=16: idle 16 cycles → player_turn toggles, no wr_en.

Source files
------------

// File: rtl/connect4_move_sequencer.sv
// rtl/connect4_move_sequencer.sv - one-move sequencer: landing row, board write, win-check handshake, status/turn
// Optional MOVE_TIMEOUT_EN: pass the turn after TIMEOUT_CYCLES idle cycles waiting for a move.
module connect4_move_sequencer #(
  parameter int ROWS           = 6,
  parameter int COLS           = 7,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] fsm_state,
  input  logic       move_valid,
  input  logic [2:0] move_col,
  output logic       move_ready,
  output logic       move_reject,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic       wr_player,
  output logic       chk_start,
  output logic [2:0] chk_row,
  output logic [2:0] chk_col,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic [1:0] game_status,
  output logic       player_turn
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [6:0] CELLS  = 7'(ROWS * COLS);
  localparam logic [2:0] ROWS_L = 3'(ROWS);
  localparam logic [2:0] COLS_L = 3'(COLS);

  logic [2:0] state;
  logic [2:0] height [COLS];
  logic [6:0] move_cnt;
  logic [2:0] cur_row;
  logic [2:0] cur_col;
  logic       win_q;
  logic [2:0] sel_height;
  logic       turn_ok;
  logic       handshake;
  logic       col_bad;
  logic       timeout_hit;

  always_comb begin
    sel_height = '0;
    for (int i = 0; i < COLS; i++) begin
      if (move_col == 3'(i)) sel_height = height[i];
    end
  end

  // The game FSM state must agree with whose turn we think it is.
  assign turn_ok    = player_turn ? (fsm_state == 2'b10) : (fsm_state == 2'b01);
  assign move_ready = (state == S_WAIT) && turn_ok;
  assign handshake  = move_valid && move_ready;
  assign col_bad    = (move_col >= COLS_L) || (sel_height == ROWS_L);

  // Row/col registers double as write address and held check coordinates.
  assign wr_row  = cur_row;
  assign wr_col  = cur_col;
  assign chk_row = cur_row;
  assign chk_col = cur_col;

`ifdef MOVE_TIMEOUT_EN
  localparam logic [25:0] IDLE_LAST = 26'(TIMEOUT_CYCLES - 1);
  logic [25:0] idle_cnt;

  assign timeout_hit = (state == S_WAIT) && !handshake && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (reset || state != S_WAIT || handshake || timeout_hit) idle_cnt <= '0;
    else                                                      idle_cnt <= idle_cnt + 26'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      move_cnt    <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      win_q       <= 1'b0;
      wr_en       <= 1'b0;
      wr_player   <= 1'b0;
      chk_start   <= 1'b0;
      move_reject <= 1'b0;
      game_status <= 2'b00;
      player_turn <= 1'b0;
      for (int i = 0; i < COLS; i++) height[i] <= '0;
    end else begin
      wr_en       <= 1'b0;
      chk_start   <= 1'b0;
      move_reject <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fsm_state == 2'b01 || fsm_state == 2'b10) state <= S_WAIT;
        end
        S_WAIT: begin
          if (handshake) begin
            if (col_bad) begin
              move_reject <= 1'b1;
            end else begin
              cur_col   <= move_col;
              cur_row   <= sel_height;
              wr_en     <= 1'b1;
              wr_player <= player_turn;
              state     <= S_WRITE;
            end
          end else if (timeout_hit) begin
            player_turn <= ~player_turn;
            game_status <= 2'b00;
          end
        end
        S_WRITE: begin
          for (int i = 0; i < COLS; i++) begin
            if (cur_col == 3'(i)) height[i] <= height[i] + 3'd1;
          end
          if (move_cnt != CELLS) move_cnt <= move_cnt + 7'd1;
          chk_start <= 1'b1;
          state     <= S_CHECK;
        end
        S_CHECK: begin
          if (chk_done) begin
            win_q <= chk_win;
            state <= S_REPORT;
          end
        end
        S_REPORT: begin
          // A win takes priority over a full board.
          if (win_q) begin
            game_status <= player_turn ? 2'b10 : 2'b01;
            state       <= S_DONE;
          end else if (move_cnt == CELLS) begin
            game_status <= 2'b11;
            state       <= S_DONE;
          end else begin
            game_status <= 2'b00;
            player_turn <= ~player_turn;
            state       <= S_WAIT;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
